// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RISC core: sequences the Datapath strobes through
// IDLE/FETCH/DECODE/EXEC/MEM/WB/HALT. Optional macro ILLEGAL_TRAP_EN traps undefined opcodes.
module multicycle_controller #(
  parameter int MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       Start,
  input  logic [4:0] opcode,
  input  logic [1:0] ALUopcode,
  input  logic [2:0] PSW_NZC,
  output logic       Buff_MEMIns,
  output logic       ALUorNot,
  output logic       LIorMOV,
  output logic       MEMresource,
  output logic       WE_MEM,
  output logic       WBresource,
  output logic       RBresource,
  output logic       oprandB,
  output logic       LI,
  output logic       PCplus1orWB,
  output logic       WE_RF,
  output logic       Branch,
  output logic       ALUop,
  output logic       Flag,
  output logic       Buff_PSW,
  output logic       Buff_PC,
  output logic [1:0] Jump,
  output logic       done,
  output logic       illegal,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  typedef struct packed {
    logic buff_memins;
    logic alu_or_not;
    logic li_or_mov;
    logic mem_resource;
    logic we_mem;
    logic wb_resource;
    logic rb_resource;
    logic oprand_b;
    logic li;
    logic pc_plus1_or_wb;
    logic we_rf;
    logic branch;
    logic alu_op;
    logic flag;
    logic buff_psw;
    logic buff_pc;
    logic done;
  } ctl_t;

  localparam logic [4:0] OP_ALU   = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00001;
  localparam logic [4:0] OP_SUBI  = 5'b00010;
  localparam logic [4:0] OP_MOV   = 5'b00011;
  localparam logic [4:0] OP_LLI   = 5'b00100;
  localparam logic [4:0] OP_LHI   = 5'b00101;
  localparam logic [4:0] OP_LDRRI = 5'b00110;
  localparam logic [4:0] OP_LDRRR = 5'b00111;
  localparam logic [4:0] OP_STRRI = 5'b01000;
  localparam logic [4:0] OP_STRRR = 5'b01001;
  localparam logic [4:0] OP_OUTR  = 5'b01010;
  localparam logic [4:0] OP_HLT   = 5'b01011;
  localparam logic [4:0] OP_BCC   = 5'b11000;
  localparam logic [4:0] OP_BCS   = 5'b11001;
  localparam logic [4:0] OP_BNE   = 5'b11010;
  localparam logic [4:0] OP_BEQ   = 5'b11011;
  localparam logic [4:0] OP_BAL   = 5'b11100;

  localparam logic [1:0] WAIT_LAST = MEM_WAIT[1:0];

  state_t     state_r, state_s;
  logic [1:0] wait_r, wait_s;
  logic       last_s;
  logic [4:0] opcode_r, opc_s;
  logic [1:0] aluopc_r, alu_s;
  logic [1:0] zc_r, zc_s;
  ctl_t       ctl_r, ctl_s;
  logic       unused_s;

  function automatic logic is_arith(input logic [4:0] opc);
    return (opc == OP_ALU) || (opc == OP_ADDI) || (opc == OP_SUBI);
  endfunction

  function automatic logic is_ldr(input logic [4:0] opc);
    return (opc == OP_LDRRI) || (opc == OP_LDRRR);
  endfunction

  function automatic logic is_str(input logic [4:0] opc);
    return (opc == OP_STRRI) || (opc == OP_STRRR);
  endfunction

  function automatic logic is_defined(input logic [4:0] opc);
    return (opc <= OP_HLT) || ((opc >= OP_BCC) && (opc <= OP_BAL));
  endfunction

  // zc = {Z, C}
  function automatic logic branch_taken(input logic [4:0] opc, input logic [1:0] zc);
    logic taken;
    case (opc)
      OP_BCC:  taken = ~zc[0];
      OP_BCS:  taken = zc[0];
      OP_BNE:  taken = ~zc[1];
      OP_BEQ:  taken = zc[1];
      OP_BAL:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

  assign unused_s = PSW_NZC[2];

  // Next-state selection and the FETCH/MEM wait counter.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:   state_s = Start ? FETCH : IDLE;
      FETCH:  state_s = (wait_r == WAIT_LAST) ? DECODE : FETCH;
      DECODE: begin
        case (opcode_r)
          OP_ALU, OP_ADDI, OP_SUBI,
          OP_LDRRI, OP_LDRRR,
          OP_STRRI, OP_STRRR:          state_s = EXEC;
          OP_MOV, OP_LLI, OP_LHI:      state_s = MEM;
          OP_BCC, OP_BCS, OP_BNE,
          OP_BEQ, OP_BAL, OP_OUTR:     state_s = FETCH;
          OP_HLT:                      state_s = HALT;
`ifdef ILLEGAL_TRAP_EN
          default:                     state_s = HALT;
`else
          default:                     state_s = FETCH;
`endif
        endcase
      end
      EXEC:   state_s = MEM;
      MEM: begin
        if (wait_r != WAIT_LAST) begin
          state_s = MEM;
        end else if (is_str(opcode_r)) begin
          state_s = FETCH;
        end else begin
          state_s = WB;
        end
      end
      WB:      state_s = FETCH;
      HALT:    state_s = HALT;
      default: state_s = IDLE;
    endcase

    if (((state_r == FETCH) || (state_r == MEM)) && (state_s == state_r)) begin
      wait_s = wait_r + 2'd1;
    end else begin
      wait_s = 2'd0;
    end
    last_s = (wait_s == WAIT_LAST);
  end

  // Opcode/flags are captured on entry to DECODE; the strobes for that cycle use the same value.
  always_comb begin
    if (state_s == DECODE) begin
      opc_s = opcode;
      alu_s = ALUopcode;
      zc_s  = PSW_NZC[1:0];
    end else begin
      opc_s = opcode_r;
      alu_s = aluopc_r;
      zc_s  = zc_r;
    end
  end

  // Strobe values for the state being entered, so the registered outputs line up with state.
  always_comb begin
    ctl_s = '0;
    case (state_s)
      FETCH: ctl_s.buff_memins = last_s;
      DECODE: begin
        case (opc_s)
          OP_ALU, OP_LDRRR, OP_STRRR, OP_MOV, OP_LLI: ctl_s = '0;
          OP_ADDI, OP_SUBI, OP_LDRRI, OP_STRRI:       ctl_s.oprand_b = 1'b1;
          OP_LHI: begin
            ctl_s.rb_resource = 1'b1;
            ctl_s.li          = 1'b1;
          end
          OP_BCC, OP_BCS, OP_BNE, OP_BEQ, OP_BAL: begin
            ctl_s.buff_pc = 1'b1;
            ctl_s.branch  = branch_taken(opc_s, zc_s);
          end
          OP_OUTR, OP_HLT: ctl_s.buff_pc = 1'b1;
`ifdef ILLEGAL_TRAP_EN
          default: ctl_s = '0;
`else
          default: ctl_s.buff_pc = 1'b1;
`endif
        endcase
      end
      EXEC: begin
        ctl_s.buff_psw    = is_arith(opc_s);
        ctl_s.alu_op      = ((opc_s == OP_ALU) && alu_s[1]) || (opc_s == OP_SUBI);
        ctl_s.flag        = (opc_s == OP_ALU) && alu_s[0];
        ctl_s.rb_resource = is_str(opc_s);
      end
      MEM: begin
        ctl_s.alu_or_not   = (opc_s == OP_MOV) || (opc_s == OP_LLI) || (opc_s == OP_LHI);
        ctl_s.li_or_mov    = (opc_s == OP_MOV);
        ctl_s.mem_resource = is_ldr(opc_s) || is_str(opc_s);
        ctl_s.we_mem       = is_str(opc_s) && last_s;
        ctl_s.buff_pc      = is_str(opc_s) && last_s;
      end
      WB: begin
        ctl_s.we_rf          = 1'b1;
        ctl_s.pc_plus1_or_wb = 1'b1;
        ctl_s.buff_pc        = 1'b1;
        ctl_s.wb_resource    = is_ldr(opc_s);
      end
      HALT:    ctl_s.done = 1'b1;
      default: ctl_s = '0;
    endcase
  end

  // State, wait counter, latched instruction fields and registered strobes.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state_r  <= IDLE;
      wait_r   <= 2'd0;
      opcode_r <= 5'd0;
      aluopc_r <= 2'd0;
      zc_r     <= 2'd0;
      ctl_r    <= '0;
    end else begin
      state_r <= state_s;
      wait_r  <= wait_s;
      ctl_r   <= ctl_s;
      opcode_r <= opc_s;
      aluopc_r <= alu_s;
      zc_r     <= zc_s;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_r;

  // Sticky trap flag, set on the same edge that enters HALT from an undefined opcode.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      illegal_r <= 1'b0;
    end else if ((state_r == DECODE) && !is_defined(opcode_r)) begin
      illegal_r <= 1'b1;
    end else begin
      illegal_r <= illegal_r;
    end
  end

  assign illegal = illegal_r;
`else
  logic unused_def_s;
  assign unused_def_s = is_defined(opcode_r);
  assign illegal      = 1'b0;
`endif

  assign Buff_MEMIns = ctl_r.buff_memins;
  assign ALUorNot    = ctl_r.alu_or_not;
  assign LIorMOV     = ctl_r.li_or_mov;
  assign MEMresource = ctl_r.mem_resource;
  assign WE_MEM      = ctl_r.we_mem;
  assign WBresource  = ctl_r.wb_resource;
  assign RBresource  = ctl_r.rb_resource;
  assign oprandB     = ctl_r.oprand_b;
  assign LI          = ctl_r.li;
  assign PCplus1orWB = ctl_r.pc_plus1_or_wb;
  assign WE_RF       = ctl_r.we_rf;
  assign Branch      = ctl_r.branch;
  assign ALUop       = ctl_r.alu_op;
  assign Flag        = ctl_r.flag;
  assign Buff_PSW    = ctl_r.buff_psw;
  assign Buff_PC     = ctl_r.buff_pc;
  assign done        = ctl_r.done;
  assign Jump        = 2'b00;
  assign state       = state_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: one MEM_WAIT=0 instance for per-instruction
// strobes and CPI, one MEM_WAIT=2 instance for the stretched FETCH/MEM timing.
module tb_multicycle_controller;

  // strobe vector bit order (MSB first):
  // Buff_MEMIns ALUorNot LIorMOV MEMresource WE_MEM WBresource RBresource oprandB
  // LI PCplus1orWB WE_RF Branch ALUop Flag Buff_PSW Buff_PC
  localparam int B_MEMINS = 15;
  localparam int B_WE_MEM = 11;
  localparam int B_WE_RF  = 5;
  localparam int B_PSW    = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, start2 = 1'b0;
  logic [4:0] opc = 5'd0, opc2 = 5'd0;
  logic [1:0] aop = 2'd0, aop2 = 2'd0;
  logic [2:0] nzc = 3'd0, nzc2 = 3'd0;

  logic [15:0] o0, o2;
  logic [1:0]  jump0, jump2;
  logic        done0, done2, ill0, ill2;
  logic [2:0]  st0, st2;

  int passed = 0, total = 0, fails = 0;
  logic [15:0] seen [0:7];
  int cyc, nrf, nmem, hit;
  logic both = 1'b0;

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_WAIT(0)) dut0 (
    .clk(clk), .Rst(rst), .Start(start), .opcode(opc), .ALUopcode(aop), .PSW_NZC(nzc),
    .Buff_MEMIns(o0[15]), .ALUorNot(o0[14]), .LIorMOV(o0[13]), .MEMresource(o0[12]),
    .WE_MEM(o0[11]), .WBresource(o0[10]), .RBresource(o0[9]), .oprandB(o0[8]),
    .LI(o0[7]), .PCplus1orWB(o0[6]), .WE_RF(o0[5]), .Branch(o0[4]), .ALUop(o0[3]),
    .Flag(o0[2]), .Buff_PSW(o0[1]), .Buff_PC(o0[0]),
    .Jump(jump0), .done(done0), .illegal(ill0), .state(st0)
  );

  multicycle_controller #(.MEM_WAIT(2)) dut2 (
    .clk(clk), .Rst(rst), .Start(start2), .opcode(opc2), .ALUopcode(aop2), .PSW_NZC(nzc2),
    .Buff_MEMIns(o2[15]), .ALUorNot(o2[14]), .LIorMOV(o2[13]), .MEMresource(o2[12]),
    .WE_MEM(o2[11]), .WBresource(o2[10]), .RBresource(o2[9]), .oprandB(o2[8]),
    .LI(o2[7]), .PCplus1orWB(o2[6]), .WE_RF(o2[5]), .Branch(o2[4]), .ALUop(o2[3]),
    .Flag(o2[2]), .Buff_PSW(o2[1]), .Buff_PC(o2[0]),
    .Jump(jump2), .done(done2), .illegal(ill2), .state(st2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic record();
    seen[st0] = seen[st0] | o0;
    nrf  += int'(o0[B_WE_RF]);
    nmem += int'(o0[B_WE_MEM]);
    if (o0[B_WE_RF] && o0[B_WE_MEM]) both = 1'b1;
  endtask

  // Runs one instruction on dut0, starting in its FETCH cycle; stops at the next FETCH or HALT.
  task automatic run(input logic [4:0] o, input logic [1:0] a, input logic [2:0] f);
    int ended;
    opc = o; aop = a; nzc = f;
    for (int i = 0; i < 8; i++) seen[i] = 16'h0000;
    cyc = 1; nrf = 0; nmem = 0; ended = 0;
    record();
    for (int i = 0; i < 40; i++) begin
      step();
      if ((st0 == 3'd1) || (st0 == 3'd6)) begin
        ended = 1;
        break;
      end
      cyc++;
      record();
    end
    chk("run_bounded", ended, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset state and abort mid-EXEC
    step(); step();
    chk("rst_state", st0, 3'd0);
    chk("rst_strobes", o0, 16'h0000);
    chk("rst_done", done0, 1'b0);
    chk("rst_illegal", ill0, 1'b0);
    chk("rst_jump", jump0, 2'b00);
    rst = 1'b0; opc = 5'b00000; aop = 2'b00; start = 1'b1;
    step();
    chk("start_fetch", st0, 3'd1);
    chk("fetch_memins", o0[B_MEMINS], 1'b1);
    start = 1'b0;
    step();
    chk("decode_state", st0, 3'd2);
    step();
    chk("exec_state", st0, 3'd3);
    chk("exec_psw", o0[B_PSW], 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_state", st0, 3'd0);
    chk("async_rst_strobes", o0, 16'h0000);
    step();
    chk("rst_no_we_rf", o0[B_WE_RF], 1'b0);
    rst = 1'b0; start = 1'b1;
    step();
    chk("restart_fetch", st0, 3'd1);
    start = 1'b0;

    // 2: small program
    run(5'b00100, 2'b00, 3'b000);           // LLI
    chk("lli_mem", seen[4], 16'h4000);
    chk("lli_we_rf", nrf, 1);
    run(5'b00101, 2'b00, 3'b000);           // LHI
    chk("lhi_decode", seen[2], 16'h0280);
    run(5'b00000, 2'b00, 3'b000);           // ADD
    chk("add_cpi", cyc, 5);
    chk("add_exec", seen[3], 16'h0002);
    chk("add_wb", seen[5], 16'h0061);
    chk("add_we_rf", nrf, 1);
    chk("add_we_mem", nmem, 0);
    run(5'b01010, 2'b00, 3'b000);           // OUTR
    chk("outr_cpi", cyc, 2);
    chk("outr_decode", seen[2], 16'h0001);

    // 3: branches
    run(5'b11011, 2'b00, 3'b010);           // BEQ, Z=1
    chk("beq_cpi", cyc, 2);
    chk("beq_decode", seen[2], 16'h0011);
    run(5'b11010, 2'b00, 3'b010);           // BNE, Z=1
    chk("bne_decode", seen[2], 16'h0001);
    run(5'b11100, 2'b00, 3'b000);           // BAL
    chk("bal_decode", seen[2], 16'h0011);
    run(5'b11000, 2'b00, 3'b001);           // BCC, C=1
    chk("bcc_decode", seen[2], 16'h0001);

    // 4: store/load and other ops
    run(5'b01000, 2'b00, 3'b000);           // STRri
    chk("str_cpi", cyc, 4);
    chk("str_decode", seen[2], 16'h0100);
    chk("str_exec", seen[3], 16'h0200);
    chk("str_mem", seen[4], 16'h1801);
    chk("str_we_mem", nmem, 1);
    chk("str_we_rf", nrf, 0);
    run(5'b00110, 2'b00, 3'b000);           // LDRri
    chk("ldr_cpi", cyc, 5);
    chk("ldr_mem", seen[4], 16'h1000);
    chk("ldr_wb", seen[5], 16'h0461);
    chk("ldr_we_rf", nrf, 1);
    chk("ldr_we_mem", nmem, 0);
    run(5'b00000, 2'b11, 3'b000);           // SBB
    chk("sbb_exec", seen[3], 16'h000E);
    run(5'b00000, 2'b01, 3'b000);           // ADC
    chk("adc_exec", seen[3], 16'h0006);
    run(5'b00010, 2'b00, 3'b000);           // SUBI
    chk("subi_exec", seen[3], 16'h000A);
    chk("subi_decode", seen[2], 16'h0100);
    run(5'b00011, 2'b00, 3'b000);           // MOV
    chk("mov_mem", seen[4], 16'h6000);
    chk("mov_no_exec", seen[3], 16'h0000);
    chk("we_overlap", both, 1'b0);

    // 6: undefined opcode
    run(5'b10000, 2'b00, 3'b000);
`ifdef ILLEGAL_TRAP_EN
    chk("undef_state", st0, 3'd6);
    chk("undef_illegal", ill0, 1'b1);
    chk("undef_done", done0, 1'b1);
`else
    chk("undef_cpi", cyc, 2);
    chk("undef_decode", seen[2], 16'h0001);
    chk("undef_illegal", ill0, 1'b0);
`endif
    rst = 1'b1;
    step();
    rst = 1'b0; start = 1'b1;
    step();
    start = 1'b0;

    // 7: HLT
    run(5'b01011, 2'b00, 3'b000);
    chk("hlt_state", st0, 3'd6);
    chk("hlt_cycles", cyc, 2);
    chk("hlt_done", done0, 1'b1);
    chk("hlt_decode", seen[2], 16'h0001);
    start = 1'b1;
    step(); step();
    start = 1'b0;
    step();
    chk("hlt_start_ignored", st0, 3'd6);
    chk("hlt_done_held", done0, 1'b1);
    rst = 1'b1;
    step();
    chk("hlt_rst_done", done0, 1'b0);
    chk("hlt_rst_state", st0, 3'd0);
    rst = 1'b0;

    // 5: MEM_WAIT=2 timing
    opc2 = 5'b00000; aop2 = 2'b00; start2 = 1'b1;
    step();
    chk("w2_fetch1", {st2, o2[B_MEMINS]}, {3'd1, 1'b0});
    start2 = 1'b0;
    step();
    chk("w2_fetch2", {st2, o2[B_MEMINS]}, {3'd1, 1'b0});
    step();
    chk("w2_fetch3", {st2, o2[B_MEMINS]}, {3'd1, 1'b1});
    step();
    chk("w2_decode", st2, 3'd2);
    cyc = 4; hit = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (st2 == 3'd1) begin
        hit = 1;
        break;
      end
      cyc++;
    end
    chk("w2_bounded", hit, 1);
    chk("w2_add_cycles", cyc, 9);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
